// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: one-bit-per-cycle shift-add multiply and
// restoring divide, with single-cycle handling of divide-by-zero and signed overflow.
module muldiv_sequencer #(
  parameter int unsigned width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [width-1:0] op_a,
  input  logic [width-1:0] op_b,
  input  logic             flush,
  output logic [width-1:0] result,
  output logic             busy_alu,
  output logic             valid_alu
);

  localparam int unsigned W     = width;
  localparam int unsigned CNT_W = $clog2(width) + 1;
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_REM    = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [W-1:0]     mag_a_q, mag_a_d;
  logic [W-1:0]     mag_b_q, mag_b_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [W-1:0]     result_q, result_d;

  logic             is_div, sgn_a, sgn_b;
  logic [W-1:0]     abs_a, abs_b;
  logic [W:0]       mul_sum, div_tmp;
  logic [W-1:0]     div_diff;
  logic             div_ge;
  logic [2*W-1:0]   step, prod;
  logic [W-1:0]     quo, rem, fin_res;

  // Operand decode at capture: sign flags and unsigned magnitudes
  always_comb begin
    is_div = funct3[2];
    sgn_a  = op_a[W-1] & ((funct3 == F_MULH) | (funct3 == F_MULHSU) |
                          (funct3 == F_DIV)  | (funct3 == F_REM));
    sgn_b  = op_b[W-1] & ((funct3 == F_MULH) | (funct3 == F_DIV) | (funct3 == F_REM));
    abs_a  = sgn_a ? (~op_a + W'(1)) : op_a;
    abs_b  = sgn_b ? (~op_b + W'(1)) : op_b;
  end

  // One iteration of the datapath and the final sign-corrected result
  always_comb begin
    // multiply: acc = {partial high, remaining multiplier bits}
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mag_a_q} : {(W+1){1'b0}});
    // divide: acc = {partial remainder, dividend bits becoming quotient bits}
    div_tmp  = {acc_q[2*W-1:W], acc_q[W-1]};
    div_ge   = (div_tmp >= {1'b0, mag_b_q});
    div_diff = div_tmp[W-1:0] - mag_b_q;
    if (op_q[2]) begin
      step = {(div_ge ? div_diff : div_tmp[W-1:0]), acc_q[W-2:0], div_ge};
    end else begin
      step = {mul_sum, acc_q[W-1:1]};
    end
    prod = neg_res_q ? (~step + (2*W)'(1)) : step;
    quo  = neg_res_q ? (~step[W-1:0] + W'(1)) : step[W-1:0];
    rem  = neg_rem_q ? (~step[2*W-1:W] + W'(1)) : step[2*W-1:W];
    if (op_q[2]) begin
      fin_res = op_q[1] ? rem : quo;
    end else begin
      fin_res = (op_q[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
    end
  end

  // Next-state, datapath update and handshake outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    mag_a_d   = mag_a_q;
    mag_b_d   = mag_b_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    acc_d     = acc_q;
    result_d  = result_q;
    busy_alu  = (state_q != S_IDLE) | (start & ~flush);
    valid_alu = (state_q == S_DONE);

    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_d      = funct3;
            mag_a_d   = abs_a;
            mag_b_d   = abs_b;
            neg_res_d = sgn_a ^ sgn_b;
            neg_rem_d = is_div & sgn_a;
            acc_d     = is_div ? {{W{1'b0}}, abs_a} : {{W{1'b0}}, abs_b};
            cnt_d     = '0;
            if (is_div && (op_b == '0)) begin
              result_d = funct3[1] ? op_a : '1;
              state_d  = S_DONE;
            end else if (is_div && !funct3[0] && (op_a == MIN_NEG) && (op_b == '1)) begin
              result_d = funct3[1] ? '0 : MIN_NEG;
              state_d  = S_DONE;
            end else begin
              state_d = S_RUN;
            end
          end
        end
        S_RUN: begin
          acc_d = step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(W - 1)) begin
            result_d = fin_res;
            state_d  = S_DONE;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      acc_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      mag_a_q   <= mag_a_d;
      mag_b_q   <= mag_b_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle RV32M multiply/divide engine and controller for the EX stage of the 5-stage pipelined RISC-V core. It accepts one M-extension operation per start and iterates it one bit per cycle. It drives `busy_alu`/`valid_alu`, which the hazard unit turns into PC/IF/ID/EX/MEM stalls. A pipeline flush aborts the operation in flight.

## Interface
- `width`, default 32: operand/result width. Iteration count equals `width`.

Ports (name, direction, width, meaning):
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `start` input 1: EX holds a valid M-extension instruction. May stay high while EX is stalled.
- `funct3` input 3: operation select.
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a` input width: rs1 value (post-forwarding).
- `op_b` input width: rs2 value (post-forwarding).
- `flush` input 1: abort the current operation (branch taken / ID flush).
- `result` output width: registered result. Valid when `valid_alu`=1, held until the next completion.
- `busy_alu` output 1: engine occupied. The pipeline must stall while `busy_alu && !valid_alu`.
- `valid_alu` output 1: one-cycle completion pulse.

## Operation
States: IDLE, RUN, DONE. Iteration counter is log2(width)+1 bits.

- **IDLE**
  - `start`=1 and `flush`=0: capture `funct3` and operand magnitudes (absolute values for signed operands: MULH both signed, MULHSU `op_a` only, DIV/REM both), plus sign flags.
  - Special cases go IDLE→DONE with the result computed at capture:
    - divide by zero: DIV/DIVU → all ones; REM/REMU → `op_a`.
    - signed overflow (DIV/REM, `op_a`=0x80000000, `op_b`=0xFFFFFFFF): DIV → 0x80000000; REM → 0.
  - All other operations go to RUN with counter cleared.
- **RUN**: one iteration per cycle; leave after exactly `width` iterations.
  - Multiply: shift-add on the unsigned magnitudes into a 2·width accumulator.
  - Divide: restoring shift-subtract producing a width-bit quotient and a width-bit remainder.
- **DONE**: `result` already loaded, `valid_alu`=1. Next state is IDLE unconditionally.
- Result selection:
  - MUL → low word; MULH/MULHSU/MULHU → high word.
  - Product is negated (2·width two's complement) when the operand signs differ (signed operands only).
  - Quotient is negated when dividend sign ≠ divisor sign; remainder takes the dividend's sign.
  - DIVU/REMU/MULHU never negate.
- `start` is sampled only in IDLE. Held-high `start` during RUN/DONE is ignored. `start` in the IDLE cycle following DONE begins a new operation (back-to-back).
- `flush`:
  - Priority over everything.
  - Any state → IDLE on the next edge. No `valid_alu`; `result` unchanged.
  - In IDLE, `flush`=1 suppresses capture.
- `busy_alu` = (state≠IDLE) | (state==IDLE & `start` & !`flush`), i.e. combinationally high in the capture cycle so the pipeline stalls immediately.
- `valid_alu` = (state==DONE), registered-state decode.

## Timing
- Reset (async, `rst_n`=0):
  - state IDLE, counter 0, `result` 0, `valid_alu` 0.
  - `busy_alu` 0 given `start`=0.
  - Operation in flight is discarded; releasing reset returns the block to IDLE.
- Normal op, `start` accepted at cycle N:
  - RUN cycles N+1..N+width.
  - DONE at N+width+1 (N+33 for width 32): `valid_alu`=1, `busy_alu`=1. Stall releases that cycle.
  - IDLE at N+width+2.
- Special case accepted at N: DONE at N+1, latency 1.
- `busy_alu`=1 continuously from N through DONE. `valid_alu` high for exactly one cycle per completed op.
- `flush` at cycle F: IDLE at F+1, `busy_alu`=0 at F+1 (unless a new `start` arrives).
- `result` updates only on the edge entering DONE.

## Test plan
- MUL `op_a`=7, `op_b`=0xFFFFFFFD, `start` at N → `valid_alu` only at N+33, `result`=0xFFFFFFEB; `busy_alu` high N..N+33.
- Multiply high variants:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- Signed divide: DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2.
- Special cases, each with `valid_alu` at N+1:
  - DIVU x/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM same operands → 0.
- `flush` at N+10 of a DIV → `busy_alu`=0 at N+11, no `valid_alu` pulse, `result` keeps its previous value. Then MUL 3×4 → 12 at +33.
- Hold `start` high through a full op followed immediately by a second op → exactly two `valid_alu` pulses, second at N+33+34. Assert `rst_n`=0 mid-RUN → outputs 0 asynchronously, no pulse after release.
